// File: rtl/nline_pf_pkg.sv
// Shared types for the next-N-line prefetcher: FSM state encoding,
// trigger queue entry layout and cache-line address alignment.
package nline_pf_pkg;

    localparam int unsigned PF_ADDR_W = 32;
    localparam int unsigned PF_WAY_W  = 1;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_REQ  = 2'd1,
        PF_DLVR = 2'd2
    } pf_state_e;

    // Plain vector constants so the state register stays a legacy logic vector
    localparam logic [1:0] ST_IDLE = PF_IDLE;
    localparam logic [1:0] ST_REQ  = PF_REQ;
    localparam logic [1:0] ST_DLVR = PF_DLVR;

    typedef struct packed {
        logic [PF_ADDR_W-1:0] line;
        logic [PF_WAY_W-1:0]  way;
    } pf_entry_t;

    function automatic logic [PF_ADDR_W-1:0] pf_line_align(
        input logic [PF_ADDR_W-1:0] addr,
        input int unsigned          line_bytes
    );
        logic [PF_ADDR_W-1:0] mask_s;
        mask_s = PF_ADDR_W'(line_bytes) - {{(PF_ADDR_W-1){1'b0}}, 1'b1};
        return addr & ~mask_s;
    endfunction

endpackage

// File: rtl/nline_prefetcher_if.sv
// Bundle of trigger, delivery and memory-read signals of the prefetcher.
// master = prefetcher side, slave = cache/memory environment side.
interface nline_prefetcher_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned WAY_W      = 1
);
    localparam int unsigned DATA_W = LINE_BYTES * 8;

    logic                prefetch_start;
    logic [ADDR_W-1:0]   cline_address;
    logic [WAY_W-1:0]    cache_way;
    logic                pf_flush;
    logic [DATA_W-1:0]   prefetch_rdata;
    logic                prefetch_ready;
    logic [ADDR_W-1:0]   pf_cline_address;
    logic [WAY_W-1:0]    pf_cache_way;
    logic                pf_busy;
    logic                pf_drop;
    logic                pf_read;
    logic [ADDR_W-1:0]   pf_address;
    logic [DATA_W-1:0]   pf_rdata;
    logic                pf_resp;

    modport master (
        input  prefetch_start, cline_address, cache_way, pf_flush, pf_rdata, pf_resp,
        output prefetch_rdata, prefetch_ready, pf_cline_address, pf_cache_way,
               pf_busy, pf_drop, pf_read, pf_address
    );

    modport slave (
        output prefetch_start, cline_address, cache_way, pf_flush, pf_rdata, pf_resp,
        input  prefetch_rdata, prefetch_ready, pf_cline_address, pf_cache_way,
               pf_busy, pf_drop, pf_read, pf_address
    );

endinterface

// File: rtl/pf_fifo.sv
// Trigger queue: synchronous FIFO with clear; clear takes effect before a
// same-cycle push, so the pushed entry lands in the emptied queue.
module pf_fifo
    import nline_pf_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  pf_entry_t        din,
    output pf_entry_t        dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    pf_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               push_ok_s;
    logic               pop_ok_s;
    logic [PTR_W-1:0]   wr_idx_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push & (clear | ~full);
    assign pop_ok_s  = pop & ~clear & ~empty;
    assign wr_idx_s  = clear ? {PTR_W{1'b0}} : wr_ptr_r;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= push ? PTR_W'(1) : {PTR_W{1'b0}};
            count_r  <= push ? CNT_W'(1) : {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_idx_s] <= din;
        end
    end

endmodule

// File: rtl/nline_prefetcher.sv
// Next-N-line prefetcher: queues miss triggers and fetches the DISTANCE lines
// following each over a single-outstanding read port. NLINE_PF_DEDUP_EN drops repeated triggers.
module nline_prefetcher
    import nline_pf_pkg::*;
#(
    parameter int unsigned ADDR_W     = PF_ADDR_W,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned WAY_W      = PF_WAY_W,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DISTANCE   = 2
) (
    input  logic               clk,
    input  logic               rst,
    nline_prefetcher_if.master bus
);

    localparam int unsigned DATA_W = LINE_BYTES * 8;
    localparam int unsigned K_W    = $clog2(DISTANCE + 1);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LINE_INC = ADDR_W'(LINE_BYTES);
    localparam logic [K_W-1:0]    K_ONE    = K_W'(1);
    localparam logic [K_W-1:0]    K_MAX    = K_W'(DISTANCE);

    logic [1:0]         state_r,    state_s;
    logic [K_W-1:0]     k_r,        k_s;
    logic [ADDR_W-1:0]  addr_r,     addr_s;
    logic [WAY_W-1:0]   way_r,      way_s;
    logic               read_r,     read_s;
    logic               ready_r,    ready_s;
    logic [DATA_W-1:0]  rdata_r,    rdata_s;
    logic [ADDR_W-1:0]  dlv_addr_r, dlv_addr_s;
    logic [WAY_W-1:0]   dlv_way_r,  dlv_way_s;
    logic               flush_pend_r, flush_pend_s;
    logic               busy_r,     busy_s;
    logic               drop_r,     drop_s;

    logic               dup_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic               q_nonempty_next_s;
    logic [CNT_W-1:0]   count_s;
    logic [ADDR_W-1:0]  trig_line_s;
    pf_entry_t          entry_s;
    pf_entry_t          head_s;

    assign trig_line_s = pf_line_align(bus.cline_address, LINE_BYTES);
    assign entry_s     = '{line: trig_line_s, way: bus.cache_way};
    // Flush empties the queue first, so a flush-cycle trigger always finds room
    assign push_s      = bus.prefetch_start & ~dup_s & (bus.pf_flush | ~full_s);
    assign drop_s      = bus.prefetch_start & ~dup_s & ~bus.pf_flush & full_s;

`ifdef NLINE_PF_DEDUP_EN
    logic               tag_valid_r;
    logic [ADDR_W-1:0]  tag_line_r;

    // Repeat of the last accepted line; a flush invalidates the tag first
    always_comb begin
        dup_s = 1'b0;
        if (tag_valid_r && !bus.pf_flush && (tag_line_r == trig_line_s)) begin
            dup_s = 1'b1;
        end else begin
            dup_s = 1'b0;
        end
    end

    // Dedup tag follows every accepted trigger
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid_r <= 1'b0;
            tag_line_r  <= {ADDR_W{1'b0}};
        end else if (push_s) begin
            tag_valid_r <= 1'b1;
            tag_line_r  <= trig_line_s;
        end else if (bus.pf_flush) begin
            tag_valid_r <= 1'b0;
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    pf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.pf_flush),
        .push  (push_s),
        .pop   (pop_s),
        .din   (entry_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Request/deliver sequencing and distance counting
    always_comb begin
        state_s      = state_r;
        k_s          = k_r;
        addr_s       = addr_r;
        way_s        = way_r;
        read_s       = read_r;
        ready_s      = 1'b0;
        rdata_s      = rdata_r;
        dlv_addr_s   = dlv_addr_r;
        dlv_way_s    = dlv_way_r;
        flush_pend_s = flush_pend_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!bus.pf_flush && !empty_s) begin
                    pop_s   = 1'b1;
                    k_s     = K_ONE;
                    addr_s  = head_s.line + LINE_INC;
                    way_s   = head_s.way;
                    read_s  = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.pf_resp) begin
                    read_s       = 1'b0;
                    flush_pend_s = 1'b0;
                    // A flush seen during the request swallows its response
                    if (flush_pend_r || bus.pf_flush) begin
                        state_s = ST_IDLE;
                    end else begin
                        ready_s    = 1'b1;
                        rdata_s    = bus.pf_rdata;
                        dlv_addr_s = addr_r;
                        dlv_way_s  = way_r;
                        state_s    = ST_DLVR;
                    end
                end else if (bus.pf_flush) begin
                    flush_pend_s = 1'b1;
                end else begin
                    flush_pend_s = flush_pend_r;
                end
            end
            ST_DLVR: begin
                if (bus.pf_flush) begin
                    state_s = ST_IDLE;
                end else if (k_r < K_MAX) begin
                    k_s     = k_r + K_ONE;
                    addr_s  = addr_r + LINE_INC;
                    read_s  = 1'b1;
                    state_s = ST_REQ;
                end else if (!empty_s) begin
                    pop_s   = 1'b1;
                    k_s     = K_ONE;
                    addr_s  = head_s.line + LINE_INC;
                    way_s   = head_s.way;
                    read_s  = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                read_s       = 1'b0;
                flush_pend_s = 1'b0;
                state_s      = ST_IDLE;
            end
        endcase
    end

    // Busy reflects the queue and state as they will be after this edge
    always_comb begin
        q_nonempty_next_s = 1'b0;
        if (bus.pf_flush) begin
            q_nonempty_next_s = push_s;
        end else begin
            q_nonempty_next_s = push_s | (count_s > {{(CNT_W-1){1'b0}}, pop_s});
        end
        busy_s = (state_s != ST_IDLE) | q_nonempty_next_s;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            k_r          <= {K_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            way_r        <= {WAY_W{1'b0}};
            read_r       <= 1'b0;
            ready_r      <= 1'b0;
            rdata_r      <= {DATA_W{1'b0}};
            dlv_addr_r   <= {ADDR_W{1'b0}};
            dlv_way_r    <= {WAY_W{1'b0}};
            flush_pend_r <= 1'b0;
            busy_r       <= 1'b0;
            drop_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            k_r          <= k_s;
            addr_r       <= addr_s;
            way_r        <= way_s;
            read_r       <= read_s;
            ready_r      <= ready_s;
            rdata_r      <= rdata_s;
            dlv_addr_r   <= dlv_addr_s;
            dlv_way_r    <= dlv_way_s;
            flush_pend_r <= flush_pend_s;
            busy_r       <= busy_s;
            drop_r       <= drop_s;
        end
    end

    assign bus.pf_read          = read_r;
    assign bus.pf_address       = addr_r;
    assign bus.prefetch_ready   = ready_r;
    assign bus.prefetch_rdata   = rdata_r;
    assign bus.pf_cline_address = dlv_addr_r;
    assign bus.pf_cache_way     = dlv_way_r;
    assign bus.pf_busy          = busy_r;
    assign bus.pf_drop          = drop_r;

endmodule

// File: tb/tb_nline_prefetcher.sv
// Scoreboard bench for nline_prefetcher: stimulus pushes expected requests and
// deliveries; a monitor pops and compares as the DUT presents them.
module tb_nline_prefetcher;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_BYTES = 32;
    localparam int unsigned WAY_W      = 1;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned DISTANCE   = 2;

    typedef struct packed {
        logic [31:0]  addr;
        logic [0:0]   way;
        logic [255:0] data;
    } dlv_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_stall = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   drops_seen = 0;
    int   mem_cnt = 0;
    logic prev_read = 1'b0;
    logic [31:0] req_q[$];
    dlv_t        dlv_q[$];

    always #5 clk = ~clk;

    nline_prefetcher_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .WAY_W(WAY_W)) bus ();

    nline_prefetcher #(
        .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .WAY_W(WAY_W),
        .DEPTH(DEPTH), .DISTANCE(DISTANCE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [255:0] mem_fn(input logic [31:0] a);
        return {a ^ 32'hC0DE0000, ~a, a + 32'd7, a, 32'h12345678, a ^ 32'hFFFF0000, a << 1, a};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_lines(input logic [31:0] base, input logic w);
        logic [31:0] a;
        for (int k = 1; k <= DISTANCE; k++) begin
            a = base + 32'(k * LINE_BYTES);
            req_q.push_back(a);
            dlv_q.push_back('{addr: a, way: w, data: mem_fn(a)});
        end
    endtask

    task automatic trig(input logic [31:0] a, input logic w);
        bus.prefetch_start = 1'b1;
        bus.cline_address  = a;
        bus.cache_way      = w;
        @(negedge clk);
        bus.prefetch_start = 1'b0;
    endtask

    task automatic wait_read(input string name);
        for (int i = 0; i < 50 && !bus.pf_read; i++) @(negedge clk);
        check(name, 256'(bus.pf_read), 256'(1'b1));
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (req_q.size() == 0) && (dlv_q.size() == 0) && !bus.pf_busy && !bus.pf_read;
        end
        check(name, 256'(done), 256'(1'b1));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 256'({bus.pf_read, bus.prefetch_ready, bus.pf_busy, bus.pf_drop,
                                    bus.pf_address, bus.pf_cline_address, bus.pf_cache_way}),
              256'(0));
        check({name, "_data"}, bus.prefetch_rdata, 256'(0));
    endtask

    // Memory: answers three cycles after a request is seen, unless stalled
    initial begin
        bus.pf_resp  = 1'b0;
        bus.pf_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst || bus.pf_resp) begin
                bus.pf_resp = 1'b0;
                mem_cnt     = 0;
            end else if (bus.pf_read && !mem_stall) begin
                mem_cnt++;
                if (mem_cnt == 3) begin
                    bus.pf_resp  = 1'b1;
                    bus.pf_rdata = mem_fn(bus.pf_address);
                    mem_cnt      = 0;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Monitor: compares new requests and deliveries against the scoreboard
    initial begin
        dlv_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.pf_read && !prev_read) begin
                    if (req_q.size() == 0) begin
                        check("req_unexpected", 256'(bus.pf_address), 256'(32'hDEAD_BEEF) ^ 256'(bus.pf_address) ^ 256'(1));
                    end else begin
                        check("req_addr", 256'(bus.pf_address), 256'(req_q.pop_front()));
                    end
                end
                if (bus.prefetch_ready) begin
                    if (dlv_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL dlv_unexpected: got delivery of %0h expected none", bus.pf_cline_address);
                    end else begin
                        e = dlv_q.pop_front();
                        check("dlv_addr", 256'(bus.pf_cline_address), 256'(e.addr));
                        check("dlv_way", 256'(bus.pf_cache_way), 256'(e.way));
                        check("dlv_data", bus.prefetch_rdata, e.data);
                    end
                end
                if (bus.pf_drop) drops_seen++;
            end
            prev_read = bus.pf_read;
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int drops_before;
        bus.prefetch_start = 1'b0;
        bus.cline_address  = '0;
        bus.cache_way      = '0;
        bus.pf_flush       = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single trigger, two lines after 0x1000
        expect_lines(32'h0000_1000, 1'b1);
        trig(32'h0000_1000, 1'b1);
        check("t1_read_after_e0", 256'(bus.pf_read), 256'(1'b0));
        @(posedge clk);
        #1;
        check("t1_read_after_e1", 256'(bus.pf_read), 256'(1'b1));
        check("t1_addr_after_e1", 256'(bus.pf_address), 256'(32'h0000_1020));
        drain("t1_drain");

        // Queue overflow while the first request stalls
        mem_stall = 1'b1;
        expect_lines(32'h0000_8000, 1'b0);
        trig(32'h0000_8000, 1'b0);
        wait_read("t2_first_read");
        drops_before = drops_seen;
        expect_lines(32'h0000_9000, 1'b1);
        expect_lines(32'h0000_A000, 1'b0);
        expect_lines(32'h0000_B000, 1'b1);
        expect_lines(32'h0000_C000, 1'b0);
        trig(32'h0000_9000, 1'b1);
        trig(32'h0000_A000, 1'b0);
        trig(32'h0000_B000, 1'b1);
        trig(32'h0000_C000, 1'b0);
        trig(32'h0000_D000, 1'b1);
        @(negedge clk);
        check("t2_drop_count", 256'(drops_seen - drops_before), 256'(1));
        mem_stall = 1'b0;
        drain("t2_drain");

        // Address wrap
        expect_lines(32'hFFFF_FFE0, 1'b0);
        trig(32'hFFFF_FFE0, 1'b0);
        drain("t3_drain");

        // Flush during a stalled request with two entries queued
        mem_stall = 1'b1;
        req_q.push_back(32'h0000_3020);
        trig(32'h0000_3000, 1'b1);
        wait_read("t4_first_read");
        trig(32'h0000_4000, 1'b0);
        trig(32'h0000_5000, 1'b1);
        bus.pf_flush = 1'b1;
        @(negedge clk);
        bus.pf_flush = 1'b0;
        check("t4_read_hold", 256'(bus.pf_read), 256'(1'b1));
        check("t4_busy_in_req", 256'(bus.pf_busy), 256'(1'b1));
        mem_stall = 1'b0;
        for (int i = 0; i < 20 && bus.pf_read; i++) @(negedge clk);
        check("t4_read_released", 256'(bus.pf_read), 256'(1'b0));
        repeat (3) @(negedge clk);
        check("t4_idle", 256'({bus.pf_busy, bus.pf_read}), 256'(0));

        // Two triggers in the same line
        expect_lines(32'h0000_2000, 1'b0);
`ifndef NLINE_PF_DEDUP_EN
        expect_lines(32'h0000_2000, 1'b0);
`endif
        trig(32'h0000_2004, 1'b0);
        trig(32'h0000_2010, 1'b0);
        drain("t5_drain");

        // Asynchronous reset mid-request, then a fresh trigger
        mem_stall = 1'b1;
        req_q.push_back(32'h0000_5020);
        trig(32'h0000_5000, 1'b1);
        wait_read("t6_read");
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        @(negedge clk);
        rst = 1'b1;
        mem_stall = 1'b0;
        @(negedge clk);
        expect_lines(32'h0000_6000, 1'b0);
        trig(32'h0000_6000, 1'b0);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nline_prefetcher.md
# nline_prefetcher

Parametrised next-N-line prefetcher between the cache miss path and the memory arbiter. Each trigger carries a missed cache-line address and its victim way. The block queues triggers, then fetches the DISTANCE consecutive lines after each one over a single-outstanding read port. Each returned line is handed back to the cache with its address and way.

## Interface
- ADDR_W, 32, address width
- LINE_BYTES, 32, cache line size in bytes (power of two); data width is LINE_BYTES*8
- WAY_W, 1, cache way index width
- DEPTH, 4, trigger queue entries (power of two, >=2)
- DISTANCE, 2, lines fetched per trigger (>=1)

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- prefetch_start  in  1  trigger strobe, one trigger per asserted cycle
- cline_address  in  ADDR_W  missed line address (low bits ignored)
- cache_way  in  WAY_W  way to fill
- pf_flush  in  1  discard queued and in-flight work
- prefetch_rdata  out  LINE_BYTES*8  fetched line
- prefetch_ready  out  1  one-cycle delivery pulse
- pf_cline_address  out  ADDR_W  line-aligned address of delivered data
- pf_cache_way  out  WAY_W  way of delivered data
- pf_busy  out  1  queue non-empty or FSM not IDLE
- pf_drop  out  1  one-cycle pulse: trigger lost because queue full
- pf_read  out  1  memory read request
- pf_address  out  ADDR_W  line-aligned request address
- pf_rdata  in  LINE_BYTES*8  memory data
- pf_resp  in  1  memory response, one cycle

## Operation
- Reset values: every output 0, queue empty, FSM IDLE, dedup tag invalid. Reset mid-request drops pf_read immediately and issues no delivery.
- Enqueue: a sampled prefetch_start with queue not full writes {cline_address & ~(LINE_BYTES-1), cache_way}.
- Full queue: the trigger is discarded and pf_drop pulses the next cycle. A pop in the same cycle does not free space for that trigger.
- FSM states: IDLE, REQ, DLVR.
- IDLE -> REQ: when the queue is non-empty, pop the head, set k=1, pf_address = base + k*LINE_BYTES, pf_read=1.
- REQ: hold pf_read and pf_address stable until pf_resp. On pf_resp: pf_read=0, capture pf_rdata, enter DLVR.
- DLVR: prefetch_ready=1 for exactly this cycle. Delivery outputs hold until the next delivery.
- Leaving DLVR:
  - if k<DISTANCE: k+1, REQ with the next address;
  - else if the queue is non-empty: pop, REQ;
  - else: IDLE.
- Address arithmetic is modulo 2^ADDR_W: base 0xFFFFFFE0, k=1 gives 0x00000000.
- pf_flush:
  - Empties the queue and clears the dedup tag.
  - From IDLE or DLVR, the FSM goes to IDLE; a DLVR pulse already visible stands.
  - From REQ, pf_read holds until pf_resp (the memory protocol is never abandoned); that response is discarded with no prefetch_ready, then IDLE.
- Flush together with trigger: the flush applies first, then the trigger is enqueued into the emptied queue.

## Timing
- Trigger sampled at edge E0 into an empty queue with the FSM IDLE: pf_read is high after E1.
- pf_resp sampled at edge Er: pf_read low and prefetch_ready high after Er. The next request (if any) is high after Er+1.
- Minimum per-line turnaround: 1 response cycle + 1 DLVR cycle.
- pf_resp while not in REQ is ignored.

## Configuration
- NLINE_PF_DEDUP_EN defined:
  - A trigger whose aligned line equals the last accepted trigger's aligned line (tag valid) is silently discarded.
  - This discard is not a pf_drop; the tag updates on every accepted trigger.
- NLINE_PF_DEDUP_EN undefined: every trigger is enqueued subject only to capacity.

## Structure
- Package nline_pf_pkg holds:
  - the state enum (IDLE, REQ, DLVR);
  - the queue entry struct {line address, way};
  - the function computing an aligned line address.
- Sub-module pf_fifo: synchronous FIFO, DEPTH entries, with full/empty, push, pop and clear. Simultaneous push and pop is allowed when not full.
- FSM, distance counter and dedup tag live in nline_prefetcher.

## Test plan
- Single trigger 0x1000 way 1, DISTANCE=2, memory answers 3 cycles after each request: requests to 0x1020 then 0x1040; two prefetch_ready pulses with matching address, way 1 and data.
- Five back-to-back triggers while the first request stalls, DEPTH=4: the fifth trigger yields a pf_drop pulse; exactly 4×DISTANCE deliveries follow in trigger order.
- Trigger base 0xFFFFFFE0: first request to 0x00000000, second to 0x00000020.
- pf_flush while in REQ with two entries queued: pf_read holds until pf_resp; no prefetch_ready; then IDLE with pf_busy=0.
- Two triggers at 0x2004 then 0x2010: with NLINE_PF_DEDUP_EN, one trigger's worth of requests; without it, two.
- rst asserted low while pf_read=1: all outputs 0 asynchronously; after release, a fresh trigger runs normally.
